cbfp_stage_2: RTL and testbench

Convergent block-floating-point normaliser placed directly downstream of FFT stage 2. It takes the 16-lane, DATA+10-bit twiddle-multiplied samples from stage 2 and groups them into blocks of BLK_CYC beats. For each block it finds the smallest number of redundant sign bits over all real and imaginary lanes, then left-shifts the whole block by that amount. Each block is re-quantised to OUT_W bits and emitted with its exponent, so stage 3 receives narrow, full-scale data.

---
 rtl/fft_pkg.sv | 16 +
 rtl/cbfp_min_sbc.sv | 36 +++
 rtl/cbfp_stage_2.sv | 183 ++++++++++++++++++
 tb/tb_cbfp_stage_2.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Definitions shared by the FFT stages: CBFP sample widths, exponent type
// and the CBFP read-side FSM states.
package fft_pkg;

  localparam int CBFP_IN_W  = 23;
  localparam int CBFP_OUT_W = 11;
  localparam int CBFP_EXP_W = 5;

  typedef logic [CBFP_EXP_W-1:0] cbfp_exp_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

endpackage

// File: rtl/cbfp_min_sbc.sv
// Combinational minimum redundant-sign-bit count over N packed IN_W-bit values.
module cbfp_min_sbc
  import fft_pkg::*;
#(
  parameter int IN_W  = CBFP_IN_W,
  parameter int N     = 32,
  parameter int CNT_W = $clog2(IN_W)
) (
  input  logic [N*IN_W-1:0] vals_i,
  output logic [CNT_W-1:0]  min_o
);

  // Per value, count the run of sign copies below the MSB; keep the smallest.
  always_comb begin
    logic [CNT_W-1:0] cnt;
    logic             run;
    min_o = CNT_W'(IN_W - 1);
    for (int v = 0; v < N; v++) begin
      cnt = {CNT_W{1'b0}};
      run = 1'b1;
      for (int b = IN_W - 2; b >= 0; b--) begin
        if (run && (vals_i[v*IN_W + b] == vals_i[v*IN_W + IN_W - 1])) begin
          cnt = cnt + CNT_W'(1);
        end else begin
          run = 1'b0;
        end
      end
      if (cnt < min_o) begin
        min_o = cnt;
      end else begin
        min_o = min_o;
      end
    end
  end

endmodule

// File: rtl/cbfp_stage_2.sv
// Convergent block-floating-point normaliser following FFT stage 2.
// Define CBFP_ROUND_EN for round-half-up with saturation; otherwise outputs truncate.
module cbfp_stage_2
  import fft_pkg::*;
#(
  parameter int IN_W    = CBFP_IN_W,
  parameter int OUT_W   = CBFP_OUT_W,
  parameter int ARRAY   = 16,
  parameter int BLK_CYC = 4,
  parameter int EXP_W   = $bits(cbfp_exp_t)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_in,
  input  logic [ARRAY*IN_W-1:0]  din_re,
  input  logic [ARRAY*IN_W-1:0]  din_im,
  output logic                   valid_out,
  output logic [ARRAY*OUT_W-1:0] dout_re,
  output logic [ARRAY*OUT_W-1:0] dout_im,
  output logic [EXP_W-1:0]       exp_out
);

  localparam int CNT_W = $clog2(BLK_CYC);
  localparam int SBC_W = $clog2(IN_W);
  localparam int MAX_S = IN_W - OUT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_CYC - 1);

  // The shift never overflows because s never exceeds the block's sign-bit count.
  function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] x,
                                             input logic [EXP_W-1:0] s);
    logic [IN_W-1:0]  sh;
    logic [OUT_W-1:0] q;
    sh = x << s;
    q  = OUT_W'(sh >> MAX_S);
`ifdef CBFP_ROUND_EN
    if (sh[MAX_S-1] && (q != {1'b0, {(OUT_W-1){1'b1}}})) begin
      q = q + OUT_W'(1);
    end else begin
      q = q;
    end
`endif
    return q;
  endfunction

  logic                   wr_bank_q;
  logic [CNT_W-1:0]       wr_cnt_q;
  logic [SBC_W-1:0]       run_min_q;
  logic [1:0]             full_q;
  logic [EXP_W-1:0]       exp_q [2];
  logic [ARRAY*IN_W-1:0]  mem_re_q [2*BLK_CYC];
  logic [ARRAY*IN_W-1:0]  mem_im_q [2*BLK_CYC];
  rd_state_t              state_q;
  logic                   rd_bank_q;
  logic [CNT_W-1:0]       rd_cnt_q;

  logic [SBC_W-1:0]       beat_min_s;
  logic [SBC_W-1:0]       blk_min_s;
  logic [EXP_W-1:0]       blk_exp_s;
  logic                   rd_done_s;
  logic [ARRAY*IN_W-1:0]  rd_re_s;
  logic [ARRAY*IN_W-1:0]  rd_im_s;
  logic [ARRAY*OUT_W-1:0] q_re_s;
  logic [ARRAY*OUT_W-1:0] q_im_s;

  cbfp_min_sbc #(
    .IN_W  (IN_W),
    .N     (2 * ARRAY),
    .CNT_W (SBC_W)
  ) u_min_sbc (
    .vals_i ({din_im, din_re}),
    .min_o  (beat_min_s)
  );

  // Running block minimum (restarted on beat 0) and its clamp to the exponent range.
  always_comb begin
    if (wr_cnt_q == {CNT_W{1'b0}}) begin
      blk_min_s = beat_min_s;
    end else if (beat_min_s < run_min_q) begin
      blk_min_s = beat_min_s;
    end else begin
      blk_min_s = run_min_q;
    end
    if (blk_min_s > SBC_W'(MAX_S)) begin
      blk_exp_s = EXP_W'(MAX_S);
    end else begin
      blk_exp_s = EXP_W'(blk_min_s);
    end
  end

  assign rd_done_s = (state_q == DRAIN) && (rd_cnt_q == LAST);
  assign rd_re_s   = mem_re_q[{rd_bank_q, rd_cnt_q}];
  assign rd_im_s   = mem_im_q[{rd_bank_q, rd_cnt_q}];

  // Write side: beat counter, running minimum, bank exponents and full flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= {CNT_W{1'b0}};
      run_min_q <= {SBC_W{1'b0}};
      full_q    <= 2'b00;
      exp_q[0]  <= {EXP_W{1'b0}};
      exp_q[1]  <= {EXP_W{1'b0}};
    end else begin
      if (rd_done_s) begin
        full_q[rd_bank_q] <= 1'b0;
      end
      if (valid_in) begin
        run_min_q <= blk_min_s;
        if (wr_cnt_q == LAST) begin
          exp_q[wr_bank_q]  <= blk_exp_s;
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
          wr_cnt_q          <= {CNT_W{1'b0}};
        end else begin
          wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Ping-pong sample storage; a bank is always drained before it is rewritten.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem_re_q[{wr_bank_q, wr_cnt_q}] <= din_re;
      mem_im_q[{wr_bank_q, wr_cnt_q}] <= din_im;
    end
  end

  // Normalise the entry currently addressed by the read side.
  always_comb begin
    q_re_s = {(ARRAY*OUT_W){1'b0}};
    q_im_s = {(ARRAY*OUT_W){1'b0}};
    for (int l = 0; l < ARRAY; l++) begin
      q_re_s[l*OUT_W +: OUT_W] = quant(rd_re_s[l*IN_W +: IN_W], exp_q[rd_bank_q]);
      q_im_s[l*OUT_W +: OUT_W] = quant(rd_im_s[l*IN_W +: IN_W], exp_q[rd_bank_q]);
    end
  end

  // Read FSM with registered outputs; chains straight into the other bank when it is full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= {CNT_W{1'b0}};
      valid_out <= 1'b0;
      dout_re   <= {(ARRAY*OUT_W){1'b0}};
      dout_im   <= {(ARRAY*OUT_W){1'b0}};
      exp_out   <= {EXP_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          valid_out <= 1'b0;
          if (full_q[~wr_bank_q]) begin
            state_q   <= DRAIN;
            rd_bank_q <= ~wr_bank_q;
            rd_cnt_q  <= {CNT_W{1'b0}};
          end
        end
        DRAIN: begin
          valid_out <= 1'b1;
          dout_re   <= q_re_s;
          dout_im   <= q_im_s;
          exp_out   <= exp_q[rd_bank_q];
          if (rd_cnt_q == LAST) begin
            rd_cnt_q <= {CNT_W{1'b0}};
            if (full_q[~rd_bank_q]) begin
              rd_bank_q <= ~rd_bank_q;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbfp_stage_2.sv
// Directed, table-driven bench for cbfp_stage_2; expectations follow CBFP_ROUND_EN.
module tb_cbfp_stage_2;

  localparam int IN_W  = 23;
  localparam int OUT_W = 11;
  localparam int ARRAY = 16;
  localparam int BLK   = 4;
  localparam int EXP_W = 5;
`ifdef CBFP_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   valid_in = 1'b0;
  logic [ARRAY*IN_W-1:0]  din_re = '0;
  logic [ARRAY*IN_W-1:0]  din_im = '0;
  logic                   valid_out;
  logic [ARRAY*OUT_W-1:0] dout_re;
  logic [ARRAY*OUT_W-1:0] dout_im;
  logic [EXP_W-1:0]       exp_out;

  always #5 clk = ~clk;

  cbfp_stage_2 dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .din_re    (din_re),
    .din_im    (din_im),
    .valid_out (valid_out),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .exp_out   (exp_out)
  );

  typedef struct {
    string name;
    int    hot;
    int    bg;
    int    e_exp;
    int    e_hot;
    int    e_bg;
  } vec_t;

  vec_t vecs[8];
  vec_t fresh;
  int   n_pass = 0;
  int   n_total = 0;
  int   lre[ARRAY];
  int   lim[ARRAY];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int l = 0; l < ARRAY; l++) begin
      lre[l] = v;
      lim[l] = v;
    end
  endtask

  task automatic drive(input logic v);
    for (int l = 0; l < ARRAY; l++) begin
      din_re[l*IN_W +: IN_W] = IN_W'(lre[l]);
      din_im[l*IN_W +: IN_W] = IN_W'(lim[l]);
    end
    valid_in = v;
  endtask

  function automatic int out_re(input int l);
    return int'($signed(dout_re[l*OUT_W +: OUT_W]));
  endfunction

  function automatic int out_im(input int l);
    return int'($signed(dout_im[l*OUT_W +: OUT_W]));
  endfunction

  function automatic int outs_zero();
    return ((dout_re == '0) && (dout_im == '0) && (exp_out == '0)) ? 1 : 0;
  endfunction

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!valid_out && lat < 20) begin
      tick();
      lat++;
    end
    if (!valid_out) $display("FAIL %s: valid_out never rose within %0d cycles", name, lat);
  endtask

  // One block: hot value in beat 0 at one lane, background elsewhere.
  task automatic run_block(input vec_t v, input int hl, input bit him, input bit gaps);
    int lat;
    int bad;
    for (int b = 0; b < BLK; b++) begin
      if (gaps) begin
        valid_in = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      fill(v.bg);
      if (b == 0) begin
        if (him) lim[hl] = v.hot;
        else     lre[hl] = v.hot;
      end
      drive(1'b1);
      tick();
    end
    valid_in = 1'b0;
    wait_valid(v.name, lat);
    chk($sformatf("%s latency", v.name), lat, 2);
    for (int b = 0; b < BLK; b++) begin
      chk($sformatf("%s valid b%0d", v.name, b), int'(valid_out), 1);
      chk($sformatf("%s exp b%0d", v.name, b), int'(exp_out), v.e_exp);
      if (b == 0) chk($sformatf("%s hot", v.name), him ? out_im(hl) : out_re(hl), v.e_hot);
      bad = v.e_bg;
      for (int l = 0; l < ARRAY; l++) begin
        if (!(b == 0 && l == hl && !him) && out_re(l) != v.e_bg) bad = out_re(l);
        if (!(b == 0 && l == hl && him)  && out_im(l) != v.e_bg) bad = out_im(l);
      end
      chk($sformatf("%s bg b%0d", v.name, b), bad, v.e_bg);
      tick();
    end
    chk($sformatf("%s valid end", v.name), int'(valid_out), 0);
  endtask

  initial begin
    int lat;
    int stray;
    vecs[0] = '{"zero",    0,           0,        12, 0,            0};
    vecs[1] = '{"one",     1,           0,        12, 1,            0};
    vecs[2] = '{"p2_20",   1 << 20,     3,        1,  512,          0};
    vecs[3] = '{"neg_rnd", -(1 << 22),  2048,     0,  -1024,        RND};
    vecs[4] = '{"neg_sat", -(1 << 22),  'h3FFFFF, 0,  -1024,        1023};
    vecs[5] = '{"neg5",    -5,          0,        12, -5,           0};
    vecs[6] = '{"k1000",   1000,        -1,       12, 1000,         -1};
    vecs[7] = '{"rnd_mid", 262400,      0,        3,  512 + RND,    0};
    fresh   = '{"fresh",   1,           0,        12, 1,            0};

    fill(0);
    drive(1'b0);
    repeat (3) tick();
    chk("reset valid", int'(valid_out), 0);
    chk("reset outs zero", outs_zero(), 1);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_block(vecs[i], (i * 5) % ARRAY, (i % 2) == 1, 1'b0);
    run_block(vecs[7], 9, 1'b0, 1'b1);
    run_block(vecs[2], 14, 1'b1, 1'b1);

    // Two back-to-back blocks: 8 contiguous valid_out cycles, exponent switches between them.
    for (int k = 0; k < 16; k++) begin
      if (k < 4) begin
        fill(0);
        if (k == 0) lre[3] = 1 << 20;
        drive(1'b1);
      end else if (k < 8) begin
        fill(1);
        drive(1'b1);
      end else begin
        valid_in = 1'b0;
      end
      tick();
      chk($sformatf("bb%0d valid", k), int'(valid_out), (k >= 5 && k <= 12) ? 1 : 0);
      if (k >= 5 && k <= 12) chk($sformatf("bb%0d exp", k), int'(exp_out), (k <= 8) ? 1 : 12);
      if (k == 5) chk("bb hot", out_re(3), 512);
      if (k >= 9 && k <= 12) chk($sformatf("bb%0d ones", k), out_im(0), 1);
    end

    // Reset while draining drops valid_out at once and discards the block.
    fill(0);
    lre[3] = 1 << 20;
    for (int b = 0; b < BLK; b++) begin
      drive(1'b1);
      tick();
    end
    valid_in = 1'b0;
    wait_valid("middrain", lat);
    rstn = 1'b0;
    #1;
    chk("middrain valid", int'(valid_out), 0);
    chk("middrain outs zero", outs_zero(), 1);
    tick();
    tick();
    rstn = 1'b1;
    stray = 0;
    repeat (8) begin
      tick();
      if (valid_out) stray++;
    end
    chk("middrain stray", stray, 0);

    // Partial block then reset: the next 4 beats must form a fresh block.
    run_block(vecs[4], 2, 1'b0, 1'b0);
    fill(-(1 << 22));
    drive(1'b1);
    tick();
    tick();
    valid_in = 1'b0;
    rstn = 1'b0;
    #1;
    chk("partial rst valid", int'(valid_out), 0);
    chk("partial rst outs zero", outs_zero(), 1);
    tick();
    chk("partial rst hold", int'(valid_out), 0);
    rstn = 1'b1;
    tick();
    run_block(fresh, 6, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
